// File: rtl/clock_display_pkg.sv
// Shared constants for the HH:MM display scanner: active-low segment codes,
// digit indices and the matching active-low anode patterns.
package clock_display_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  localparam logic [1:0] DIG_HR_T = 2'd0;
  localparam logic [1:0] DIG_HR_O = 2'd1;
  localparam logic [1:0] DIG_MN_T = 2'd2;
  localparam logic [1:0] DIG_MN_O = 2'd3;

  localparam logic [3:0] AN_HR_T = 4'b0111;
  localparam logic [3:0] AN_HR_O = 4'b1011;
  localparam logic [3:0] AN_MN_T = 4'b1101;
  localparam logic [3:0] AN_MN_O = 4'b1110;
  localparam logic [3:0] AN_OFF  = 4'b1111;

  function automatic logic [3:0] an_pattern(input logic [1:0] idx);
    logic [3:0] pat;
    case (idx)
      DIG_HR_T: pat = AN_HR_T;
      DIG_HR_O: pat = AN_HR_O;
      DIG_MN_T: pat = AN_MN_T;
      default:  pat = AN_MN_O;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low 7-segment decoder; dash wins over blank,
// blank wins over the digit value.
module seg7_decode
  import clock_display_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  input  logic       dash,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (dash) begin
      seg = SEG_DASH;
    end else if (!blank) begin
      case (bcd)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/clock_display_scan.sv
// 4-digit multiplexed HH:MM display driver with colon blink and PM dot.
// Optional macro LEADING_ZERO_EN shows a zero hour-tens digit instead of blanking it.
module clock_display_scan
  import clock_display_pkg::*;
#(
  parameter int SCAN_DIV  = 2,
  parameter int BLINK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] min,
  input  logic [4:0] hrs,
  input  logic       AM,
  input  logic       PM,
  output logic [6:0] seg_n,
  output logic [3:0] an_n,
  output logic       dp_n
);

  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

  logic [PRE_W-1:0] pre;
  logic [1:0]       idx;
  logic [BLK_W-1:0] blink_cnt;
  logic             blink;
  logic             fresh;
  logic [5:0]       min_s;
  logic [4:0]       hrs_s;
  logic             am_s;
  logic             pm_s;

  logic pre_last;
  logic load;

  assign pre_last = (pre == PRE_LAST);
  // Loading only at frame end keeps every frame consistent with one time sample.
  assign load     = fresh || (pre_last && (idx == DIG_MN_O));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
      idx <= DIG_HR_T;
    end else begin
      pre <= pre_last ? '0 : pre + 1'b1;
      if (pre_last) idx <= idx + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      blink     <= 1'b0;
    end else if (blink_cnt == BLK_LAST) begin
      blink_cnt <= '0;
      blink     <= ~blink;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fresh <= 1'b1;
      min_s <= '0;
      hrs_s <= '0;
      am_s  <= 1'b0;
      pm_s  <= 1'b0;
    end else if (load) begin
      fresh <= 1'b0;
      min_s <= min;
      hrs_s <= hrs;
      am_s  <= AM;
      pm_s  <= PM;
    end
  end

  logic       valid;
  logic [3:0] hr_tens, hr_ones, mn_tens, mn_ones;
  logic [3:0] bcd;
  logic       blank;
  logic       dp_next;
  logic [6:0] seg_next;

  assign valid   = (min_s <= 6'd59) && (hrs_s <= 5'd23) && !(am_s && pm_s);
  assign hr_tens = 4'(hrs_s / 5'd10);
  assign hr_ones = 4'(hrs_s % 5'd10);
  assign mn_tens = 4'(min_s / 6'd10);
  assign mn_ones = 4'(min_s % 6'd10);

  always_comb begin
    bcd     = 4'd0;
    blank   = 1'b0;
    dp_next = 1'b1;
    case (idx)
      DIG_HR_T: begin
        bcd = hr_tens;
`ifdef LEADING_ZERO_EN
        blank = 1'b0;
`else
        blank = (hr_tens == 4'd0);
`endif
      end
      DIG_HR_O: begin
        bcd     = hr_ones;
        dp_next = ~blink;
      end
      DIG_MN_T: bcd = mn_tens;
      default: begin
        bcd     = mn_ones;
        dp_next = ~pm_s;
      end
    endcase
    if (!valid) dp_next = 1'b1;
  end

  seg7_decode u_decode (
    .bcd   (bcd),
    .blank (blank),
    .dash  (!valid),
    .seg   (seg_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_n <= SEG_BLANK;
      an_n  <= AN_OFF;
      dp_n  <= 1'b1;
    end else begin
      seg_n <= seg_next;
      an_n  <= an_pattern(idx);
      dp_n  <= dp_next;
    end
  end

endmodule

// File: tb/tb_clock_display_scan.sv
// Directed bench for clock_display_scan with SCAN_DIV=2, BLINK_DIV=2:
// one frame is 8 edges, shadow loads on edge 1 and every 8th edge after reset.
module tb_clock_display_scan;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] min = '0;
  logic [4:0] hrs = '0;
  logic       AM = 1'b0;
  logic       PM = 1'b0;
  logic [6:0] seg_n;
  logic [3:0] an_n;
  logic       dp_n;

  int checks = 0;
  int errors = 0;
  int ecnt = 0;

`ifdef LEADING_ZERO_EN
  localparam logic [6:0] HT0 = 7'h40;
`else
  localparam logic [6:0] HT0 = 7'h7F;
`endif

  logic [3:0] an_tab [4];
  logic [6:0] es [4];

  always #5 clk = ~clk;

  clock_display_scan #(.SCAN_DIV(2), .BLINK_DIV(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .min   (min),
    .hrs   (hrs),
    .AM    (AM),
    .PM    (PM),
    .seg_n (seg_n),
    .an_n  (an_n),
    .dp_n  (dp_n)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    ecnt++;
  endtask

  task automatic skip_frame();
    repeat (8) tick();
  endtask

  // Colon expected on the idx1 slot: blink toggles on every 2nd edge after reset.
  function automatic logic colon_exp(input int k);
    return (((k - 1) / 2) % 2 == 1) ? 1'b0 : 1'b1;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    hrs = 5'd13; min = 6'd25; AM = 1'b0; PM = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (seg_n !== 7'h7F) begin errors++; $display("FAIL reset seg_n got %h want 7f", seg_n); end
    checks++; if (an_n !== 4'hF) begin errors++; $display("FAIL reset an_n got %b want 1111", an_n); end
    checks++; if (dp_n !== 1'b1) begin errors++; $display("FAIL reset dp_n got %b want 1", dp_n); end
    rst_n = 1'b1;
    ecnt = 0;
    tick();
    checks++; if (an_n !== 4'b0111) begin errors++; $display("FAIL first_edge an_n got %b want 0111", an_n); end
    checks++; if (seg_n !== HT0) begin errors++; $display("FAIL first_edge seg_n got %h want %h", seg_n, HT0); end
  endtask

  task automatic test_24h();
    logic exp_dp;
    int d;
    es = '{7'h79, 7'h30, 7'h24, 7'h12};
    for (int i = 1; i < 16; i++) begin
      tick();
      d = (i / 2) % 4;
      exp_dp = (d == 1) ? colon_exp(ecnt) : 1'b1;
      checks++; if (an_n !== an_tab[d]) begin errors++; $display("FAIL 24h an_n k%0d got %b want %b", ecnt, an_n, an_tab[d]); end
      checks++; if (seg_n !== es[d]) begin errors++; $display("FAIL 24h seg_n k%0d got %h want %h", ecnt, seg_n, es[d]); end
      checks++; if (dp_n !== exp_dp) begin errors++; $display("FAIL 24h dp_n k%0d got %b want %b", ecnt, dp_n, exp_dp); end
    end
  endtask

  task automatic test_leading_zero();
    logic exp_dp;
    int d;
    hrs = 5'd9; min = 6'd5; AM = 1'b1; PM = 1'b0;
    skip_frame();
    es = '{HT0, 7'h10, 7'h40, 7'h12};
    for (int i = 0; i < 8; i++) begin
      tick();
      d = i / 2;
      exp_dp = (d == 1) ? colon_exp(ecnt) : 1'b1;
      checks++; if (an_n !== an_tab[d]) begin errors++; $display("FAIL lz an_n k%0d got %b want %b", ecnt, an_n, an_tab[d]); end
      checks++; if (seg_n !== es[d]) begin errors++; $display("FAIL lz seg_n k%0d got %h want %h", ecnt, seg_n, es[d]); end
      checks++; if (dp_n !== exp_dp) begin errors++; $display("FAIL lz dp_n k%0d got %b want %b", ecnt, dp_n, exp_dp); end
    end
  endtask

  task automatic test_pm_colon();
    logic exp_dp;
    int d;
    hrs = 5'd1; min = 6'd0; AM = 1'b0; PM = 1'b1;
    skip_frame();
    es = '{HT0, 7'h79, 7'h40, 7'h40};
    for (int i = 0; i < 16; i++) begin
      tick();
      d = (i / 2) % 4;
      exp_dp = (d == 1) ? colon_exp(ecnt) : (d == 3) ? 1'b0 : 1'b1;
      checks++; if (seg_n !== es[d]) begin errors++; $display("FAIL pm seg_n k%0d got %h want %h", ecnt, seg_n, es[d]); end
      checks++; if (dp_n !== exp_dp) begin errors++; $display("FAIL pm dp_n k%0d got %b want %b", ecnt, dp_n, exp_dp); end
    end
  endtask

  task automatic test_tear_free();
    int d;
    hrs = 5'd13; min = 6'd25; AM = 1'b0; PM = 1'b0;
    skip_frame();
    es = '{7'h79, 7'h30, 7'h24, 7'h12};
    for (int i = 0; i < 8; i++) begin
      tick();
      d = i / 2;
      if (i == 3) min = 6'd26;
      checks++; if (seg_n !== es[d]) begin errors++; $display("FAIL tear_old seg_n k%0d got %h want %h", ecnt, seg_n, es[d]); end
    end
    es = '{7'h79, 7'h30, 7'h24, 7'h02};
    for (int i = 0; i < 8; i++) begin
      tick();
      d = i / 2;
      checks++; if (seg_n !== es[d]) begin errors++; $display("FAIL tear_new seg_n k%0d got %h want %h", ecnt, seg_n, es[d]); end
    end
  endtask

  task automatic test_invalid();
    int d;
    hrs = 5'd13; min = 6'd60; AM = 1'b0; PM = 1'b0;
    skip_frame();
    for (int i = 0; i < 8; i++) begin
      tick();
      d = i / 2;
      if (i == 0) min = 6'd59;
      checks++; if (an_n !== an_tab[d]) begin errors++; $display("FAIL inv_min an_n k%0d got %b want %b", ecnt, an_n, an_tab[d]); end
      checks++; if (seg_n !== 7'h3F) begin errors++; $display("FAIL inv_min seg_n k%0d got %h want 3f", ecnt, seg_n); end
      checks++; if (dp_n !== 1'b1) begin errors++; $display("FAIL inv_min dp_n k%0d got %b want 1", ecnt, dp_n); end
    end
    es = '{7'h79, 7'h30, 7'h12, 7'h10};
    for (int i = 0; i < 8; i++) begin
      tick();
      d = i / 2;
      if (i == 0) begin AM = 1'b1; PM = 1'b1; end
      checks++; if (seg_n !== es[d]) begin errors++; $display("FAIL recover seg_n k%0d got %h want %h", ecnt, seg_n, es[d]); end
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 0) begin AM = 1'b0; PM = 1'b0; min = 6'd25; end
      checks++; if (seg_n !== 7'h3F) begin errors++; $display("FAIL inv_ampm seg_n k%0d got %h want 3f", ecnt, seg_n); end
      checks++; if (dp_n !== 1'b1) begin errors++; $display("FAIL inv_ampm dp_n k%0d got %b want 1", ecnt, dp_n); end
    end
  endtask

  task automatic test_reset_mid();
    repeat (5) tick();
    checks++; if (an_n !== 4'b1101) begin errors++; $display("FAIL mid_pre an_n got %b want 1101", an_n); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (seg_n !== 7'h7F) begin errors++; $display("FAIL mid_rst seg_n got %h want 7f", seg_n); end
    checks++; if (an_n !== 4'hF) begin errors++; $display("FAIL mid_rst an_n got %b want 1111", an_n); end
    checks++; if (dp_n !== 1'b1) begin errors++; $display("FAIL mid_rst dp_n got %b want 1", dp_n); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (an_n !== 4'hF) begin errors++; $display("FAIL mid_hold an_n got %b want 1111", an_n); end
    rst_n = 1'b1;
    ecnt = 0;
    tick();
    checks++; if (an_n !== 4'b0111) begin errors++; $display("FAIL mid_k1 an_n got %b want 0111", an_n); end
    tick();
    checks++; if (an_n !== 4'b0111) begin errors++; $display("FAIL mid_k2 an_n got %b want 0111", an_n); end
    checks++; if (seg_n !== 7'h79) begin errors++; $display("FAIL mid_k2 seg_n got %h want 79", seg_n); end
    tick();
    checks++; if (an_n !== 4'b1011) begin errors++; $display("FAIL mid_k3 an_n got %b want 1011", an_n); end
    checks++; if (seg_n !== 7'h30) begin errors++; $display("FAIL mid_k3 seg_n got %h want 30", seg_n); end
  endtask

  initial begin
    an_tab = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
    test_reset();
    test_24h();
    test_leading_zero();
    test_pm_colon();
    test_tear_free();
    test_invalid();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
